bc_control_unit: RTL



---
 rtl/bc_ctrl_pkg.sv | 79 +++++++
 rtl/bc_seq_counter.sv | 14 +
 rtl/bc_control_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bc_ctrl_pkg.sv
// bc_ctrl_pkg: shared constants, codes and state type for the BC_I control unit.
// The PAUSE state only exists when BC_CU_SINGLE_STEP_EN is defined.
package bc_ctrl_pkg;
  localparam int LD_AR   = 0;
  localparam int INR_AR  = 1;
  localparam int CLR_AR  = 2;
  localparam int LD_PC   = 3;
  localparam int INR_PC  = 4;
  localparam int CLR_PC  = 5;
  localparam int LD_DR   = 6;
  localparam int INR_DR  = 7;
  localparam int CLR_DR  = 8;
  localparam int LD_AC   = 9;
  localparam int INR_AC  = 10;
  localparam int CLR_AC  = 11;
  localparam int LD_IR   = 12;
  localparam int LD_TR   = 13;
  localparam int INR_TR  = 14;
  localparam int CLR_TR  = 15;
  localparam int MEM_WE  = 16;
  localparam int ALU_LSB = 17;
  localparam int ALU_MSB = 19;

  localparam logic [2:0] BUS_AR  = 3'd0;
  localparam logic [2:0] BUS_PC  = 3'd1;
  localparam logic [2:0] BUS_DR  = 3'd2;
  localparam logic [2:0] BUS_AC  = 3'd3;
  localparam logic [2:0] BUS_IR  = 3'd4;
  localparam logic [2:0] BUS_TR  = 3'd5;
  localparam logic [2:0] BUS_MEM = 3'd6;
  localparam logic [2:0] BUS_WRD = 3'd7;

  localparam logic [2:0] ALU_PASS_DR = 3'd0;
  localparam logic [2:0] ALU_AND     = 3'd1;
  localparam logic [2:0] ALU_ADD     = 3'd2;
  localparam logic [2:0] ALU_CMA     = 3'd3;
  localparam logic [2:0] ALU_SHR     = 3'd4;
  localparam logic [2:0] ALU_SHL     = 3'd5;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_LDA    = 3'd2;
  localparam logic [2:0] OP_STA    = 3'd3;
  localparam logic [2:0] OP_BUN    = 3'd4;
  localparam logic [2:0] OP_BSA    = 3'd5;
  localparam logic [2:0] OP_ISZ    = 3'd6;
  localparam logic [2:0] OP_REG_IO = 3'd7;

  localparam logic [3:0] RR_HLT  = 4'd0;
  localparam logic [3:0] RR_SZE  = 4'd1;
  localparam logic [3:0] RR_SZA  = 4'd2;
  localparam logic [3:0] RR_SNA  = 4'd3;
  localparam logic [3:0] RR_SPA  = 4'd4;
  localparam logic [3:0] RR_INC  = 4'd5;
  localparam logic [3:0] RR_CIL  = 4'd6;
  localparam logic [3:0] RR_CIR  = 4'd7;
  localparam logic [3:0] RR_CME  = 4'd8;
  localparam logic [3:0] RR_CMA  = 4'd9;
  localparam logic [3:0] RR_CLE  = 4'd10;
  localparam logic [3:0] RR_CLA  = 4'd11;
  localparam logic [3:0] RR_NONE = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
`ifdef BC_CU_SINGLE_STEP_EN
    ST_HALT,
    ST_PAUSE
`else
    ST_HALT
`endif
  } state_t;

  // Highest set bit of the register-reference field wins; RR_NONE when empty.
  function automatic logic [3:0] rr_pick(input logic [11:0] v);
    rr_pick = RR_NONE;
    for (int k = 0; k < 12; k++) if (v[k]) rr_pick = 4'(k);
  endfunction
endpackage

// File: rtl/bc_seq_counter.sv
// bc_seq_counter: T-step sequence counter; synchronous clear has priority over increment.
module bc_seq_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q;
  always_ff @(posedge clk) cnt_q <= (rst || clr_i) ? '0 : inc_i ? cnt_q + 1'b1 : cnt_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/bc_control_unit.sv
// bc_control_unit: hardwired fetch/decode/execute sequencer for the BC_I accumulator machine.
// Define BC_CU_SINGLE_STEP_EN to add the STEP input and a PAUSE state after every instruction.
module bc_control_unit
  import bc_ctrl_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CTRL_LNGTH = 20,
  parameter int SC_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  START,
`ifdef BC_CU_SINGLE_STEP_EN
  input  logic                  STEP,
`endif
  input  logic [WIDTH-1:0]      IR_IN,
  input  logic [WIDTH-1:0]      AC_IN,
  input  logic [WIDTH-1:0]      DR_IN,
  output logic [2:0]            BUS_SEL,
  output logic [CTRL_LNGTH-1:0] CTRL_SGNLS,
  output logic                  E_LD,
  output logic                  E_CMP,
  output logic                  E_RST,
  output logic [SC_WIDTH-1:0]   SC_OUT,
  output logic                  BUSY,
  output logic                  HALTED
);
  state_t state_q, state_d;
  logic i_q;
  logic [SC_WIDTH-1:0] sc;
  logic [2:0] d, bus;
  logic [CTRL_LNGTH-1:0] ctrl;
  logic e_ld, e_cmp, e_rst, sc_clr, hlt, run;

  assign d   = IR_IN[WIDTH-2:WIDTH-4];
  assign run = state_q == ST_RUN && !RST;

  bc_seq_counter #(.WIDTH(SC_WIDTH)) u_sc (
    .clk  (clk),
    .rst  (RST),
    .clr_i(state_q != ST_RUN || sc_clr),
    .inc_i(1'b1),
    .cnt_o(sc)
  );

  always_ff @(posedge clk) begin
    state_q <= RST ? ST_IDLE : state_d;
    i_q     <= RST ? 1'b0 : (state_q == ST_RUN && sc == SC_WIDTH'(2)) ? IR_IN[WIDTH-1] : i_q;
  end

  always_comb begin
    bus    = BUS_AR;
    ctrl   = '0;
    e_ld   = 1'b0;
    e_cmp  = 1'b0;
    e_rst  = 1'b0;
    hlt    = 1'b0;
    sc_clr = sc >= SC_WIDTH'(7);
    case (32'(sc))
      0: begin
        bus = BUS_PC;
        ctrl[LD_AR] = 1'b1;
      end
      1: begin
        bus = BUS_MEM;
        ctrl[LD_IR] = 1'b1;
        ctrl[INR_PC] = 1'b1;
      end
      2: begin
        bus = BUS_IR;
        ctrl[LD_AR] = 1'b1;
      end
      3: if (d != OP_REG_IO) begin
        bus = i_q ? BUS_MEM : BUS_AR;
        ctrl[LD_AR] = i_q;
      end else begin
        sc_clr = 1'b1;
        if (!i_q)
          case (rr_pick(IR_IN[11:0]))
            RR_CLA: ctrl[CLR_AC] = 1'b1;
            RR_CLE: e_rst = 1'b1;
            RR_CMA: begin
              ctrl[LD_AC] = 1'b1;
              ctrl[ALU_MSB:ALU_LSB] = ALU_CMA;
            end
            RR_CME: e_cmp = 1'b1;
            RR_CIR: begin
              ctrl[LD_AC] = 1'b1;
              ctrl[ALU_MSB:ALU_LSB] = ALU_SHR;
              e_ld = 1'b1;
            end
            RR_CIL: begin
              ctrl[LD_AC] = 1'b1;
              ctrl[ALU_MSB:ALU_LSB] = ALU_SHL;
              e_ld = 1'b1;
            end
            RR_INC: ctrl[INR_AC] = 1'b1;
            RR_SPA: ctrl[INR_PC] = !AC_IN[WIDTH-1];
            RR_SNA: ctrl[INR_PC] = AC_IN[WIDTH-1];
            RR_SZA: ctrl[INR_PC] = AC_IN == '0;
            RR_HLT: hlt = 1'b1;
            default: ;
          endcase
      end
      4: case (d)
        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
          bus = BUS_MEM;
          ctrl[LD_DR] = 1'b1;
        end
        OP_STA: begin
          bus = BUS_AC;
          ctrl[MEM_WE] = 1'b1;
          sc_clr = 1'b1;
        end
        OP_BUN: begin
          ctrl[LD_PC] = 1'b1;
          sc_clr = 1'b1;
        end
        OP_BSA: begin
          bus = BUS_PC;
          ctrl[MEM_WE] = 1'b1;
          ctrl[INR_AR] = 1'b1;
        end
        default: ;
      endcase
      5: case (d)
        OP_AND, OP_ADD, OP_LDA: begin
          ctrl[LD_AC] = 1'b1;
          ctrl[ALU_MSB:ALU_LSB] = d == OP_AND ? ALU_AND : d == OP_ADD ? ALU_ADD : ALU_PASS_DR;
          e_ld = d == OP_ADD;
          sc_clr = 1'b1;
        end
        OP_BSA: begin
          ctrl[LD_PC] = 1'b1;
          sc_clr = 1'b1;
        end
        OP_ISZ: ctrl[INR_DR] = 1'b1;
        default: ;
      endcase
      6: if (d == OP_ISZ) begin
        bus = BUS_DR;
        ctrl[MEM_WE] = 1'b1;
        ctrl[INR_PC] = DR_IN == '0;
        sc_clr = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = START ? ST_RUN : ST_IDLE;
`ifdef BC_CU_SINGLE_STEP_EN
      ST_RUN:   state_d = hlt ? ST_HALT : sc_clr ? ST_PAUSE : ST_RUN;
      ST_PAUSE: state_d = STEP ? ST_RUN : ST_PAUSE;
`else
      ST_RUN:   state_d = hlt ? ST_HALT : ST_RUN;
`endif
      default: ;
    endcase
  end

  assign BUS_SEL    = run ? bus : BUS_AR;
  assign CTRL_SGNLS = run ? ctrl : '0;
  assign E_LD       = run && e_ld;
  assign E_CMP      = run && e_cmp;
  assign E_RST      = run && e_rst;
  assign SC_OUT     = RST ? '0 : sc;
  assign BUSY       = run;
  assign HALTED     = !RST && state_q == ST_HALT;
endmodule
